// File: rtl/serial_twoscomp_rx.sv
// Bit-serial two's-complement negator: accepts an LSB-first word, negates it on the fly
// (copy up to and including the first 1, complement the rest) and presents the word in parallel.
module serial_twoscomp_rx #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             ack,
  input  logic             clr,
  output logic [WIDTH-1:0] dout,
  output logic             done,
  output logic             busy,
  output logic             ovf
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COPY  = 2'd1,
    S_COMPL = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_shreg;
  logic [WIDTH-1:0] w_shreg_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [WIDTH-1:0] r_dout;
  logic [WIDTH-1:0] w_dout_nxt;
  logic             r_ovf;
  logic             w_ovf_nxt;
  logic             r_done;
  logic             r_busy;

  logic             w_last;
  logic             w_new_bit;
  logic [WIDTH-1:0] w_shifted;

  assign w_last    = (r_cnt == LAST_CNT);
  // Once the first 1 has been passed, every later bit is inverted.
  assign w_new_bit = (r_state == S_COMPL) ? ~bit_in : bit_in;
  assign w_shifted = {w_new_bit, r_shreg[WIDTH-1:1]};

  always_comb begin
    w_state_nxt = r_state;
    w_shreg_nxt = r_shreg;
    w_cnt_nxt   = r_cnt;
    w_dout_nxt  = r_dout;
    w_ovf_nxt   = r_ovf;

    if (clr) begin
      w_state_nxt = S_IDLE;
      w_shreg_nxt = '0;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            w_state_nxt = S_COPY;
            w_shreg_nxt = '0;
            w_cnt_nxt   = '0;
          end
        end

        S_COPY, S_COMPL: begin
          if (bit_valid) begin
            w_shreg_nxt = w_shifted;
            w_cnt_nxt   = r_cnt + CNT_W'(1);
            if (w_last) begin
              w_state_nxt = S_DONE;
              w_dout_nxt  = w_shifted;
              // A lone 1 at the MSB means the input was the most negative value.
              w_ovf_nxt   = (r_state == S_COPY) && bit_in;
            end else if (r_state == S_COPY && bit_in) begin
              w_state_nxt = S_COMPL;
            end
          end
        end

        S_DONE: begin
          if (ack) begin
            w_state_nxt = S_IDLE;
          end
        end

        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_shreg <= '0;
      r_cnt   <= '0;
      r_dout  <= '0;
      r_ovf   <= 1'b0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_shreg <= w_shreg_nxt;
      r_cnt   <= w_cnt_nxt;
      r_dout  <= w_dout_nxt;
      r_ovf   <= w_ovf_nxt;
      r_done  <= (w_state_nxt == S_DONE);
      r_busy  <= (w_state_nxt == S_COPY) || (w_state_nxt == S_COMPL);
    end
  end

  assign dout = r_dout;
  assign done = r_done;
  assign busy = r_busy;
  assign ovf  = r_ovf;

endmodule

// File: tb/tb_serial_twoscomp_rx.sv
// Randomised self-checking bench for serial_twoscomp_rx against an arithmetic negation model.
module tb_serial_twoscomp_rx;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         bit_in;
  logic         bit_valid;
  logic         ack;
  logic         clr;
  logic [W-1:0] dout;
  logic         done;
  logic         busy;
  logic         ovf;

  int errors = 0;
  int checks = 0;

  logic [W-1:0] exp_dout;
  logic         exp_ovf;

  serial_twoscomp_rx #(.WIDTH(W), .CNT_W(5)) dut (
    .clk(clk), .reset(reset), .start(start), .bit_in(bit_in),
    .bit_valid(bit_valid), .ack(ack), .clr(clr),
    .dout(dout), .done(done), .busy(busy), .ovf(ovf)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] ref_neg(input logic [W-1:0] x);
    longint full;
    full = (longint'(1) << W) - longint'(x);
    return W'(full % (longint'(1) << W));
  endfunction

  function automatic logic ref_ovf(input logic [W-1:0] x);
    return longint'(x) == (longint'(1) << (W - 1));
  endfunction

  // Raise start for one cycle; a stray valid bit alongside it must be ignored.
  task automatic do_start();
    start     = 1'b1;
    bit_valid = 1'b1;
    bit_in    = 1'($urandom);
    @(negedge clk);
    start     = 1'b0;
    bit_valid = 1'b0;
  endtask

  task automatic feed_bits(input logic [W-1:0] x, input int nbits, input int maxgap);
    bit gap_bad, hold_bad;
    int g;
    gap_bad  = 1'b0;
    hold_bad = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      g = int'($urandom_range(maxgap, 0));
      for (int k = 0; k < g; k++) begin
        bit_valid = 1'b0;
        bit_in    = 1'($urandom);
        @(negedge clk);
        if (busy !== 1'b1 || done !== 1'b0) gap_bad = 1'b1;
      end
      bit_valid = 1'b1;
      bit_in    = x[i];
      @(negedge clk);
      if (i < W - 1) begin
        if (done !== 1'b0 || busy !== 1'b1 || dout !== exp_dout || ovf !== exp_ovf) hold_bad = 1'b1;
      end
    end
    bit_valid = 1'b0;
    checks++;
    if (gap_bad) begin
      errors++;
      $display("FAIL gap_busy: busy/done wrong during bit_valid gaps for word %h (required busy=1 done=0)", x);
    end
    checks++;
    if (hold_bad) begin
      errors++;
      $display("FAIL mid_word_hold: outputs changed mid-word for %h (required dout=%h ovf=%b done=0 busy=1)",
               x, exp_dout, exp_ovf);
    end
  endtask

  task automatic send_word(input logic [W-1:0] x, input int maxgap, input bit do_ack);
    int d;
    do_start();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL start_busy: busy=%b required 1 after start", busy);
    end
    feed_bits(x, W, maxgap);
    exp_dout = ref_neg(x);
    exp_ovf  = ref_ovf(x);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || dout !== exp_dout || ovf !== exp_ovf) begin
      errors++;
      $display("FAIL word_%h: done=%b busy=%b dout=%h ovf=%b required done=1 busy=0 dout=%h ovf=%b",
               x, done, busy, dout, ovf, exp_dout, exp_ovf);
    end
    if (do_ack) begin
      d = int'($urandom_range(2, 0));
      for (int k = 0; k < d; k++) begin
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || dout !== exp_dout) begin
          errors++;
          $display("FAIL done_hold: done=%b dout=%h required done=1 dout=%h", done, dout, exp_dout);
        end
      end
      ack = 1'b1;
      @(negedge clk);
      ack = 1'b0;
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || dout !== exp_dout || ovf !== exp_ovf) begin
        errors++;
        $display("FAIL ack_idle: done=%b busy=%b dout=%h ovf=%b required 0 0 %h %b",
                 done, busy, dout, ovf, exp_dout, exp_ovf);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #1;
    checks++;
    if (dout !== '0 || done !== 1'b0 || busy !== 1'b0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: dout=%h done=%b busy=%b ovf=%b required all 0", dout, done, busy, ovf);
    end
    exp_dout = '0;
    exp_ovf  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    send_word(16'h0001, 0, 1'b1);
    send_word(16'h0000, 0, 1'b1);
    send_word(16'h8000, 0, 1'b1);
    send_word(16'h7FFF, 0, 1'b1);
    send_word(16'h00A0, 3, 1'b1);
    send_word(16'hFFFF, 1, 1'b1);
  endtask

  task automatic test_reset_mid_word();
    do_start();
    feed_bits(16'h1234, 7, 1);
    reset = 1'b0;
    #1;
    checks++;
    if (dout !== '0 || done !== 1'b0 || busy !== 1'b0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_word: dout=%h done=%b busy=%b ovf=%b required all 0", dout, done, busy, ovf);
    end
    exp_dout = '0;
    exp_ovf  = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    send_word(16'h1234, 0, 1'b1);
  endtask

  task automatic test_start_with_ack();
    send_word(16'h8000, 0, 1'b0);
    start = 1'b1;
    ack   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ack   = 1'b0;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL start_ack_idle: done=%b busy=%b required 0 0", done, busy);
    end
    bit_valid = 1'b1;
    bit_in    = 1'b1;
    repeat (3) @(negedge clk);
    bit_valid = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || dout !== exp_dout || ovf !== exp_ovf) begin
      errors++;
      $display("FAIL no_new_word: busy=%b done=%b dout=%h ovf=%b required 0 0 %h %b",
               busy, done, dout, ovf, exp_dout, exp_ovf);
    end
    send_word(16'h0002, 1, 1'b1);
  endtask

  task automatic test_clr();
    do_start();
    feed_bits(16'h0003, 5, 1);
    clr       = 1'b1;
    bit_valid = 1'b1;
    start     = 1'b1;
    @(negedge clk);
    clr       = 1'b0;
    bit_valid = 1'b0;
    start     = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || dout !== exp_dout || ovf !== exp_ovf) begin
      errors++;
      $display("FAIL clr_mid_word: busy=%b done=%b dout=%h ovf=%b required 0 0 %h %b",
               busy, done, dout, ovf, exp_dout, exp_ovf);
    end
    send_word(16'h0003, 1, 1'b1);
    send_word(16'h0C00, 0, 1'b0);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || dout !== exp_dout) begin
      errors++;
      $display("FAIL clr_in_done: done=%b busy=%b dout=%h required 0 0 %h", done, busy, dout, exp_dout);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] x;
    for (int n = 0; n < 25; n++) begin
      case ($urandom_range(4, 0))
        0:       x = 16'h8000;
        1:       x = 16'h0000;
        default: x = W'($urandom);
      endcase
      send_word(x, int'($urandom_range(3, 0)), 1'b1);
      if ($urandom_range(1, 0) == 1) @(negedge clk);
    end
  endtask

  initial begin
    start     = 1'b0;
    bit_in    = 1'b0;
    bit_valid = 1'b0;
    ack       = 1'b0;
    clr       = 1'b0;
    exp_dout  = '0;
    exp_ovf   = 1'b0;
    test_reset();
    test_directed();
    test_reset_mid_word();
    test_start_with_ack();
    test_clr();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_twoscomp_rx.md
Name: serial_twoscomp_rx

Overview:
Bit-serial receiver for the two's-complement datapath. It accepts an LSB-first serial bit stream, negates it on the fly with the copy-until-first-one / complement-remainder rule, and assembles the WIDTH-bit parallel result. It is the serial-in/parallel-out counterpart of the parallel-in rotating negator and feeds parallel consumers such as the complex-multiplier operand registers.

Parameters:
WIDTH, 16, word length in bits; legal range is 2 to 32.
CNT_W, 5, bit-counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-low reset; clk and reset are the only clock and reset.
start  input  1  begin a new word; sampled only in IDLE.
bit_in  input  1  serial data bit, LSB first.
bit_valid  input  1  bit_in is valid this cycle; gaps between valid bits are allowed.
ack  input  1  consumer has taken dout; sampled only in DONE.
clr  input  1  synchronous abort; returns to IDLE from any state.
dout  output  WIDTH  negated word; updated only on entry to DONE.
done  output  1  result valid; high for the whole of DONE.
busy  output  1  high in COPY and COMPL.
ovf  output  1  the input word was the most negative value (1 followed by WIDTH-1 zeros), so the result equals the input.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; shreg, cnt, dout, done, busy and ovf are all 0.
- States: IDLE, COPY, COMPL, DONE; all outputs are registered.
- IDLE
  - start=1 -> COPY; shreg and cnt cleared.
  - bit_valid is ignored, including in the same cycle as start; the first bit is accepted the cycle after start.
- COPY, on bit_valid=1:
  - shreg <= {bit_in, shreg[WIDTH-1:1]} (shift right, new bit enters at the MSB); cnt <= cnt+1.
  - bit_in=1 -> COMPL, unless this is the last bit.
- COMPL, on bit_valid=1:
  - shreg <= {~bit_in, shreg[WIDTH-1:1]}; cnt <= cnt+1.
- Last bit (cnt==WIDTH-1 with bit_valid=1) in COPY or COMPL:
  - -> DONE; dout <= the final shifted value in the same edge.
  - ovf <= 1 only if the last bit arrived in COPY with bit_in=1; otherwise ovf <= 0.
- bit_valid=0 in COPY or COMPL: hold all state.
- Latency: done rises on the clock edge that samples the WIDTH-th valid bit. The minimum word time is 1 (start) + WIDTH cycles.
- DONE
  - done=1; dout and ovf are held.
  - ack=1 -> IDLE; done falls next cycle.
  - start is ignored in DONE; start together with ack does not start a new word, and a fresh start is needed in IDLE.
- IDLE retains dout and ovf from the previous word; they are overwritten only by the next completion.
- Outside IDLE, start is ignored (no restart mid-word).
- clr=1 in any state -> IDLE next edge; cnt and shreg cleared; done and busy go to 0; dout and ovf are held. clr has priority over start, bit_valid and ack.
- Reset asserted mid-word: immediate return to reset values; the partial word is discarded.
- Arithmetic: result = (2^WIDTH - x) mod 2^WIDTH.
  - x=0 stays in COPY throughout and gives 0, with ovf=0.
  - No widening: the result is WIDTH bits.

Test Plan:
- Send 0x0001 LSB-first with back-to-back valid bits -> done after 16 valid bits, dout=0xFFFF, ovf=0, then ack -> IDLE.
- Send 0x0000 -> dout=0x0000, ovf=0; the FSM never enters COMPL.
- Send 0x8000 -> dout=0x8000, ovf=1; send 0x7FFF next -> dout=0x8001, ovf cleared to 0.
- Send 0x00A0 with bit_valid=0 gaps of 1-3 cycles -> dout=0xFF60; busy stays high throughout the gaps.
- Assert reset low after 7 bits of 0x1234 -> all outputs 0 at once; the next full word 0x1234 -> dout=0xEDCC.
- In DONE, assert start and ack together -> IDLE, no new word begun. clr after 5 bits of 0x0003 -> IDLE with dout holding its prior value, and the next word is received correctly.
